// File: rtl/gprs_writeback_queue.sv
// gprs_writeback_queue: writeback FIFO draining one entry per cycle into the GPR write port.
// Define GPRS_WBQ_BYPASS_EN to forward pending entries onto RS1o/RS2o; otherwise reads pass straight through.
module gprs_writeback_queue #(
    parameter  int ZERO  = 1,
    parameter  int WIDTH = 32,
    parameter  int UNITS = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(UNITS),
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQv,
    output logic             REQr,
    input  logic [AW-1:0]    REQs,
    input  logic [WIDTH-1:0] REQd,
    output logic             WEN,
    output logic [AW-1:0]    DSTs,
    output logic [WIDTH-1:0] DSTi,
    input  logic [AW-1:0]    RS1s,
    input  logic [AW-1:0]    RS2s,
    input  logic [WIDTH-1:0] RS1g,
    input  logic [WIDTH-1:0] RS2g,
    output logic [WIDTH-1:0] RS1o,
    output logic [WIDTH-1:0] RS2o,
    output logic [CW-1:0]    CNT,
    output logic             BUSY
);
    logic [AW-1:0]    dst_q  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy, push;
    // Outputs are gated by RST so a pending head is never written on the reset edge.
    assign busy  = RST && (cnt_q != '0);
    assign REQr  = RST && (cnt_q < CW'(DEPTH));
    assign push  = REQv && REQr && !(ZERO != 0 && REQs == '0);
    assign cnt_d = cnt_q + CW'(push) - CW'(busy);
    assign WEN   = busy;
    assign BUSY  = busy;
    assign CNT   = RST ? cnt_q : '0;
    assign DSTs  = busy ? dst_q[rp_q] : '0;
    assign DSTi  = busy ? data_q[rp_q] : '0;
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                dst_q[wp_q]  <= REQs;
                data_q[wp_q] <= REQd;
                wp_q         <= wp_q + 1'b1;
            end
            if (busy) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
`ifdef GPRS_WBQ_BYPASS_EN
    logic [WIDTH-1:0] rs1_fwd, rs2_fwd;
    // Walk from head to tail so the youngest matching entry wins.
    always_comb begin
        rs1_fwd = RS1g;
        rs2_fwd = RS2g;
        for (int i = 0; i < DEPTH; i++) begin
            rs1_fwd = (CW'(i) < CNT && dst_q[rp_q + PW'(i)] == RS1s) ? data_q[rp_q + PW'(i)] : rs1_fwd;
            rs2_fwd = (CW'(i) < CNT && dst_q[rp_q + PW'(i)] == RS2s) ? data_q[rp_q + PW'(i)] : rs2_fwd;
        end
    end
    assign RS1o = (ZERO != 0 && RS1s == '0) ? '0 : rs1_fwd;
    assign RS2o = (ZERO != 0 && RS2s == '0) ? '0 : rs2_fwd;
`else
    logic unused_sel;
    assign unused_sel = ^{RS1s, RS2s};
    assign RS1o = RS1g;
    assign RS2o = RS2g;
`endif
endmodule
